// File: rtl/mem_wr_responder.sv
// Write responder: strobes accepted writes to memory and returns in-order acks after a fixed age.
// Optional address-range error reporting is enabled by defining MEM_WR_RESP_ERR_EN.
module mem_wr_responder #(
    parameter int TidWidth   = 2,
    parameter int AddrWidth  = 64,
    parameter int DataWidth  = 64,
    parameter int QueueDepth = 8,
    parameter int AckLatency = 2
`ifdef MEM_WR_RESP_ERR_EN
    ,
    parameter logic [AddrWidth-1:0] ErrAddrBase = '0,
    parameter logic [AddrWidth-1:0] ErrAddrLen  = '0
`endif
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [TidWidth-1:0]            req_tid_i,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [DataWidth-1:0]           req_data_i,
    input  logic [DataWidth/8-1:0]         req_be_i,
    output logic                           mem_we_o,
    output logic [AddrWidth-1:0]           mem_addr_o,
    output logic [DataWidth-1:0]           mem_wdata_o,
    output logic [DataWidth/8-1:0]         mem_be_o,
    output logic                           ack_valid_o,
    input  logic                           ack_ready_i,
    output logic [TidWidth-1:0]            ack_tid_o,
    output logic [$clog2(QueueDepth):0]    outstanding_o
`ifdef MEM_WR_RESP_ERR_EN
    ,
    output logic                           ack_err_o
`endif
);

    localparam int   PtrW     = $clog2(QueueDepth);
    localparam int   CntW     = PtrW + 1;
    localparam logic PushAged = (AckLatency <= 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    state_e                state_q;
    logic [TidWidth-1:0]   tid_q   [QueueDepth];
    logic [3:0]            stamp_q [QueueDepth];
    logic [3:0]            age_nxt [QueueDepth];
    logic [QueueDepth-1:0] aged_q;
    logic [QueueDepth-1:0] aged_nxt;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [PtrW-1:0]       rd_nxt;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_nxt;
    logic [3:0]            ts_q;
    logic                  accept;
    logic                  pop;
    logic                  req_err;
    logic                  head_is_push;
    logic                  head_aged;
    logic [TidWidth-1:0]   head_tid;
    logic                  load_head;

`ifdef MEM_WR_RESP_ERR_EN
    logic [QueueDepth-1:0] err_q;
    logic                  head_err;

    assign req_err = (req_addr_i >= ErrAddrBase) &&
                     ((req_addr_i - ErrAddrBase) < ErrAddrLen);
`else
    assign req_err = 1'b0;
`endif

    assign outstanding_o = cnt_q;

    always_comb begin
        accept       = req_valid_i & req_ready_o;
        pop          = ack_valid_o & ack_ready_i;
        cnt_nxt      = cnt_q + CntW'(accept) - CntW'(pop);
        rd_nxt       = rd_ptr_q + PtrW'(pop);
        head_is_push = accept && ((cnt_q - CntW'(pop)) == '0);
        // Age as seen after this edge; sticky so a long wait past counter wrap stays aged.
        for (int i = 0; i < QueueDepth; i++) begin
            age_nxt[i]  = ts_q + 4'd1 - stamp_q[i];
            aged_nxt[i] = aged_q[i] | (age_nxt[i] >= 4'(AckLatency));
        end
        head_aged = head_is_push ? PushAged  : aged_nxt[rd_nxt];
        head_tid  = head_is_push ? req_tid_i : tid_q[rd_nxt];
        load_head = 1'b0;
        unique case (state_q)
            IDLE:    load_head = accept;
            WAIT:    load_head = head_aged;
            ACK:     load_head = pop && (cnt_nxt != '0);
            default: load_head = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ts_q        <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            aged_q      <= '0;
            req_ready_o <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            ack_valid_o <= 1'b0;
            ack_tid_o   <= '0;
            for (int i = 0; i < QueueDepth; i++) begin
                tid_q[i]   <= '0;
                stamp_q[i] <= '0;
            end
        end else begin
            ts_q        <= ts_q + 4'd1;
            cnt_q       <= cnt_nxt;
            req_ready_o <= cnt_nxt < CntW'(QueueDepth);
            mem_we_o    <= accept & ~req_err;
            rd_ptr_q    <= rd_nxt;
            aged_q      <= aged_nxt;
            if (accept) begin
                mem_addr_o        <= req_addr_i;
                mem_wdata_o       <= req_data_i;
                mem_be_o          <= req_be_i;
                tid_q[wr_ptr_q]   <= req_tid_i;
                stamp_q[wr_ptr_q] <= ts_q;
                aged_q[wr_ptr_q]  <= PushAged;
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
            end
            if (load_head)
                ack_tid_o <= head_tid;
            unique case (state_q)
                IDLE: if (accept) begin
                    state_q     <= head_aged ? ACK : WAIT;
                    ack_valid_o <= head_aged;
                end
                WAIT: if (head_aged) begin
                    state_q     <= ACK;
                    ack_valid_o <= 1'b1;
                end
                ACK: if (pop) begin
                    if (cnt_nxt == '0) begin
                        state_q     <= IDLE;
                        ack_valid_o <= 1'b0;
                    end else begin
                        state_q     <= head_aged ? ACK : WAIT;
                        ack_valid_o <= head_aged;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ack_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_WR_RESP_ERR_EN
    assign head_err = head_is_push ? req_err : err_q[rd_nxt];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q     <= '0;
            ack_err_o <= 1'b0;
        end else begin
            if (accept)
                err_q[wr_ptr_q] <= req_err;
            if (load_head)
                ack_err_o <= head_err;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wr_responder.sv
// Directed bench for mem_wr_responder: latency, fill, backpressure, overlap, reset.
// Error-range checks run only when MEM_WR_RESP_ERR_EN is defined.
module tb_mem_wr_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_tid_i = '0;
    logic [63:0] req_addr_i = '0;
    logic [63:0] req_data_i = '0;
    logic [7:0]  req_be_i = '0;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_be_o;
    logic        ack_valid_o;
    logic        ack_ready_i = 1'b0;
    logic [1:0]  ack_tid_o;
    logic [3:0]  outstanding_o;
`ifdef MEM_WR_RESP_ERR_EN
    logic        ack_err_o;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    mem_wr_responder #(
        .TidWidth(2), .AddrWidth(64), .DataWidth(64),
        .QueueDepth(8), .AckLatency(2)
`ifdef MEM_WR_RESP_ERR_EN
        , .ErrAddrBase(64'h1000), .ErrAddrLen(64'h100)
`endif
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_tid_i(req_tid_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_be_i(req_be_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .ack_valid_o(ack_valid_o), .ack_ready_i(ack_ready_i),
        .ack_tid_o(ack_tid_o), .outstanding_o(outstanding_o)
`ifdef MEM_WR_RESP_ERR_EN
        , .ack_err_o(ack_err_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] tid,
                         input logic [63:0] addr);
        req_valid_i = v;
        req_tid_i   = tid;
        req_addr_i  = addr;
        req_data_i  = {addr[31:0], 32'hA5A5_0000 | 32'(tid)};
        req_be_i    = 8'hFF;
    endtask

    logic [1:0] fill_tids [8] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [1:0] ovl_tids  [3] = '{2'd1, 2'd2, 2'd3};
    int         acks;

    initial begin
        tick();
        tick();
        check("rst_ready", req_ready_o, 1);
        check("rst_we", mem_we_o, 0);
        check("rst_ackv", ack_valid_o, 0);
        check("rst_out", outstanding_o, 0);
        check("rst_tid", ack_tid_o, 0);
        check("rst_addr", mem_addr_o, 0);
        rst_i = 1'b0;
        tick();

        // single write
        ack_ready_i = 1'b1;
        drive(1, 2'd2, 64'h8000_0000);
        tick();
        drive(0, 0, 0);
        check("s_we", mem_we_o, 1);
        check("s_addr", mem_addr_o, 64'h8000_0000);
        check("s_be", mem_be_o, 8'hFF);
        check("s_data", mem_wdata_o, 64'h8000_0000_A5A5_0002);
        check("s_ackv_early", ack_valid_o, 0);
        check("s_out1", outstanding_o, 1);
        tick();
        check("s_we_off", mem_we_o, 0);
        check("s_ackv", ack_valid_o, 1);
        check("s_tid", ack_tid_o, 2);
        tick();
        check("s_ackv_off", ack_valid_o, 0);
        check("s_out0", outstanding_o, 0);

        // fill with 9 requests, acks blocked
        ack_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1, fill_tids[i % 8], 64'h100 + 64'(i * 8));
            tick();
        end
        drive(0, 0, 0);
        check("f_out8", outstanding_o, 8);
        check("f_ready0", req_ready_o, 0);
        check("f_last_addr", mem_addr_o, 64'h138);
        ack_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("f_ackv%0d", i), ack_valid_o, 1);
            check($sformatf("f_tid%0d", i), ack_tid_o, fill_tids[i]);
            tick();
            if (i == 0) check("f_ready_after1", req_ready_o, 1);
        end
        check("f_ackv_done", ack_valid_o, 0);
        check("f_out_done", outstanding_o, 0);

        // backpressure
        ack_ready_i = 1'b0;
        drive(1, 2'd1, 64'h40);
        tick();
        drive(0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_v%0d", i), ack_valid_o, 1);
            check($sformatf("bp_t%0d", i), ack_tid_o, 1);
            tick();
        end
        ack_ready_i = 1'b1;
        tick();
        check("bp_rel_v", ack_valid_o, 0);
        check("bp_rel_out", outstanding_o, 0);
        tick();
        check("bp_once", ack_valid_o, 0);

        // simultaneous accept and ack at outstanding 3
        ack_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'(i), 64'h200 + 64'(i));
            tick();
        end
        drive(0, 0, 0);
        tick();
        check("ov_out3", outstanding_o, 3);
        check("ov_head", ack_tid_o, 0);
        drive(1, 2'd3, 64'h300);
        ack_ready_i = 1'b1;
        tick();
        drive(0, 0, 0);
        check("ov_out_same", outstanding_o, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ov_v%0d", i), ack_valid_o, 1);
            check($sformatf("ov_t%0d", i), ack_tid_o, ovl_tids[i]);
            tick();
        end
        check("ov_done", outstanding_o, 0);

        // reset with pending writes
        ack_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'(i), 64'h400 + 64'(i));
            tick();
        end
        drive(0, 0, 0);
        tick();
        check("r_pend", outstanding_o, 4);
        #2 rst_i = 1'b1;
        #1;
        check("r_ackv", ack_valid_o, 0);
        check("r_out", outstanding_o, 0);
        check("r_ready", req_ready_o, 1);
        check("r_we", mem_we_o, 0);
        check("r_tid", ack_tid_o, 0);
        check("r_addr", mem_addr_o, 0);
        check("r_data", mem_wdata_o, 0);
        tick();
        rst_i = 1'b0;
        ack_ready_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_valid_o) acks++;
        end
        check("r_noack", 64'(acks), 0);
        check("r_out_post", outstanding_o, 0);

`ifdef MEM_WR_RESP_ERR_EN
        drive(1, 2'd1, 64'h1010);
        tick();
        drive(0, 0, 0);
        check("e_we_blk", mem_we_o, 0);
        tick();
        check("e_ackv", ack_valid_o, 1);
        check("e_err1", ack_err_o, 1);
        tick();
        drive(1, 2'd2, 64'h2000);
        tick();
        drive(0, 0, 0);
        check("e_we_ok", mem_we_o, 1);
        tick();
        check("e_ackv2", ack_valid_o, 1);
        check("e_err0", ack_err_o, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wr_responder.md
MEM_WR_RESPONDER -- requirements
Module: mem_wr_responder

Interface
REQ-001 Parameter TidWidth, default 2: width of write transaction ID.
REQ-002 Parameter AddrWidth, default 64: request address width.
REQ-003 Parameter DataWidth, default 64: write data width; byte-enable width = DataWidth/8.
REQ-004 Parameter QueueDepth, default 8: outstanding-write capacity, power of two, at least 2.
REQ-005 Parameter AckLatency, default 2: minimum cycles from accept to ack-valid, 1..15.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 req_valid_i  in  1  write request valid.
REQ-009 req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-010 req_tid_i  in  TidWidth  transaction ID.
REQ-011 req_addr_i  in  AddrWidth  byte address.
REQ-012 req_data_i / req_be_i  in  DataWidth / DataWidth/8  write data and byte enables.
REQ-013 mem_we_o  out  1  one-cycle write strobe to backing store.
REQ-014 mem_addr_o / mem_wdata_o / mem_be_o  out  AddrWidth / DataWidth / DataWidth/8  registered copy of the accepted request.
REQ-015 ack_valid_o  out  1  write acknowledge valid.
REQ-016 ack_ready_i  in  1  acknowledge consumed when valid and ready are both high.
REQ-017 ack_tid_o  out  TidWidth  ID being acknowledged.
REQ-018 outstanding_o  out  clog2(QueueDepth)+1  accepted-but-unacknowledged count.

Function
REQ-019 On acceptance, mem_we_o SHALL pulse high in the next cycle, with mem_addr_o/mem_wdata_o/mem_be_o holding the request fields.
REQ-020 Each accepted request SHALL push {tid, issue timestamp} into an in-order FIFO of QueueDepth entries.
REQ-021 req_ready_o SHALL be high if and only if outstanding_o < QueueDepth; it SHALL not depend combinationally on req_valid_i.
REQ-022 Head FSM states SHALL be IDLE (FIFO empty), WAIT (head age < AckLatency), and ACK (ack_valid_o high).
REQ-023 FSM transitions SHALL be:
- IDLE->WAIT on push;
- WAIT->ACK when the head has spent AckLatency cycles in the FIFO;
- ACK->WAIT on handshake when the next entry is not yet aged;
- ACK stays ACK on handshake when the next entry is already aged, giving back-to-back acks;
- ACK->IDLE on handshake when the FIFO becomes empty.
REQ-024 Acks SHALL be returned strictly in acceptance order; ack_tid_o SHALL equal the head tid.
REQ-025 While ack_valid_o is high and ack_ready_i is low, ack_valid_o and ack_tid_o SHALL hold stable.
REQ-026 Entry age SHALL use a free-running 4-bit timestamp with modulo-16 subtraction, so counter wrap does not change ack timing.
REQ-027 outstanding_o update rules:
- +1 on accept only;
- -1 on ack handshake only;
- unchanged when both occur in the same cycle.
REQ-028 When full and an ack handshake occurs, req_ready_o SHALL rise in the next cycle, not the same cycle.
REQ-029 Duplicate tids SHALL be permitted and acknowledged independently.

Reset
REQ-030 While rst_i is high, the block SHALL hold the following values:
- FSM in IDLE; FIFO pointers, timestamp and outstanding_o at 0;
- req_ready_o at 1;
- mem_we_o and ack_valid_o at 0;
- all data outputs at 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending acks; no ack SHALL be issued after deassertion for pre-reset requests.

Configuration
REQ-032 Macro MEM_WR_RESP_ERR_EN, when defined, SHALL add parameters ErrAddrBase/ErrAddrLen (default 0/0) and output ack_err_o (1 bit).
REQ-033 With the macro defined, ack_err_o SHALL be high with an ack when its request address was in [ErrAddrBase, ErrAddrBase+ErrAddrLen), and mem_we_o SHALL NOT pulse for such requests.
REQ-034 Without the macro, ack_err_o and the range parameters SHALL not exist, and every accepted request SHALL strobe mem_we_o.

Verification
REQ-035 Single write: tid=2, addr=0x8000_0000, be=0xFF, ack_ready_i=1 -> mem_we_o in cycle 1; ack_valid_o with tid=2 exactly AckLatency=2 cycles after accept; outstanding_o returns 0.
REQ-036 Fill: 9 back-to-back requests, ack_ready_i=0 -> 8 accepted, req_ready_o low, outstanding_o=8; then ack_ready_i=1 -> 8 consecutive acks in order, req_ready_o high after the first ack.
REQ-037 Backpressure: ack_ready_i held low for 5 cycles -> ack_valid_o and ack_tid_o stable; exactly one ack on release.
REQ-038 Simultaneous accept and ack at outstanding_o=3 -> outstanding_o stays 3.
REQ-039 Reset with 4 pending writes -> all outputs at reset values; no ack within 20 cycles after deassertion.
REQ-040 With MEM_WR_RESP_ERR_EN, ErrAddrBase=0x1000, ErrAddrLen=0x100: write to 0x1010 -> no mem_we_o, ack_err_o=1; write to 0x2000 -> mem_we_o, ack_err_o=0.
